// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed scan controller for a common-anode 7-segment
// display. Double-buffered hex data is swapped in only at frame wrap.
// Features: leading-zero blanking, 3-bit brightness PWM and a guard band
// with all anodes off at the start of every digit slot.
module seg7_scan_ctrl #(
    parameter int NDIG       = 4,
    parameter int SLOT_TICKS = 2,
    parameter int GUARD_CLKS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce1ms,
    input  logic [4*NDIG-1:0] data_in,
    input  logic [NDIG-1:0]   dp_in,
    input  logic              load,
    input  logic              blank_lz,
    input  logic [2:0]        bright,
    output logic [NDIG-1:0]   an,
    output logic [6:0]        seg,
    output logic              dp,
    output logic              load_ack,
    output logic              frame
);

    localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int SW = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
    localparam int GW = $clog2(GUARD_CLKS + 1);

    typedef enum logic {S_GUARD, S_ON} state_t;

    state_t             state_q, state_d;
    logic [DW-1:0]      dig_q, dig_d;
    logic [GW-1:0]      gcnt_q, gcnt_d;
    logic [SW-1:0]      slot_q, slot_d;
    logic [7:0]         p_q, p_d;
    logic [4*NDIG-1:0]  act_q, act_d, pbuf_q, pbuf_d;
    logic [NDIG-1:0]    adp_q, adp_d, pdp_q, pdp_d;
    logic               pend_q, pend_d;
    logic               wrap_q, wrap_d;
    logic               ack_q, ack_d;
    logic [NDIG-1:0]    an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic               frame_q, load_ack_q;
    logic               slot_end;

    // Active-low gfedcba hex decode.
    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    // Scan FSM next state: slot end (counted in ce1ms pulses) overrides guard timing.
    always_comb begin
        state_d  = state_q;
        gcnt_d   = gcnt_q;
        slot_d   = slot_q;
        dig_d    = dig_q;
        wrap_d   = 1'b0;
        p_d      = p_q + 8'd1;
        slot_end = ce1ms && (slot_q == SW'(SLOT_TICKS - 1));
        if (ce1ms) slot_d = slot_end ? '0 : slot_q + 1'b1;
        if (slot_end) begin
            state_d = S_GUARD;
            gcnt_d  = '0;
            wrap_d  = (dig_q == DW'(NDIG - 1));
            dig_d   = wrap_d ? '0 : dig_q + 1'b1;
        end else begin
            case (state_q)
                S_GUARD: begin
                    if (gcnt_q == GW'(GUARD_CLKS - 1)) begin
                        state_d = S_ON;
                        gcnt_d  = '0;
                    end else begin
                        gcnt_d = gcnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Double buffer: swap at wrap uses the old pending data, so a load in the wrap cycle waits a frame.
    always_comb begin
        ack_d  = wrap_d && pend_q;
        act_d  = ack_d ? pbuf_q : act_q;
        adp_d  = ack_d ? pdp_q : adp_q;
        pbuf_d = load ? data_in : pbuf_q;
        pdp_d  = load ? dp_in : pdp_q;
        pend_d = load ? 1'b1 : (ack_d ? 1'b0 : pend_q);
    end

    // Pin values for the current digit: decode, leading-zero blanking and PWM-gated anode.
    always_comb begin
        logic [3:0] nib;
        logic       dpb;
        logic       upper_zero;
        logic       blanked;
        nib        = '0;
        dpb        = 1'b0;
        upper_zero = 1'b1;
        an_d       = '1;
        for (int k = 0; k < NDIG; k++) begin
            if (DW'(k) == dig_q) begin
                nib = act_q[4*k +: 4];
                dpb = adp_q[k];
            end
            if (k >= int'(dig_q) && act_q[4*k +: 4] != 4'h0) upper_zero = 1'b0;
        end
        blanked = blank_lz && (dig_q != '0) && upper_zero;
        seg_d   = blanked ? 7'h7F : hex7(nib);
        dp_d    = blanked ? 1'b1 : ~dpb;
        if (state_q == S_ON && p_q[7:5] <= bright) begin
            for (int k = 0; k < NDIG; k++)
                if (DW'(k) == dig_q) an_d[k] = 1'b0;
        end
    end

    // State and output registers; frame/load_ack are delayed one clk to line up with the guard outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_GUARD;
            dig_q      <= '0;
            gcnt_q     <= '0;
            slot_q     <= '0;
            p_q        <= '0;
            act_q      <= '0;
            adp_q      <= '0;
            pbuf_q     <= '0;
            pdp_q      <= '0;
            pend_q     <= 1'b0;
            wrap_q     <= 1'b0;
            ack_q      <= 1'b0;
            an_q       <= '1;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            frame_q    <= 1'b0;
            load_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dig_q      <= dig_d;
            gcnt_q     <= gcnt_d;
            slot_q     <= slot_d;
            p_q        <= p_d;
            act_q      <= act_d;
            adp_q      <= adp_d;
            pbuf_q     <= pbuf_d;
            pdp_q      <= pdp_d;
            pend_q     <= pend_d;
            wrap_q     <= wrap_d;
            ack_q      <= ack_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            frame_q    <= wrap_q;
            load_ack_q <= ack_q;
        end
    end

    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = dp_q;
    assign frame    = frame_q;
    assign load_ack = load_ack_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: every cycle is compared with a slot/time based
// reference model, plus directed scenario checks and a randomized phase.
module tb_seg7_scan_ctrl;

    localparam int NDIG   = 4;
    localparam int SLOT   = 2;
    localparam int G      = 16;
    localparam int CE_PER = 300;

    localparam logic [6:0] SEGTAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce1ms = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [2:0]  bright = 3'd7;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, load_ack, frame;

    seg7_scan_ctrl #(.NDIG(NDIG), .SLOT_TICKS(SLOT), .GUARD_CLKS(G)) dut (
        .clk(clk), .rst(rst), .ce1ms(ce1ms), .data_in(data_in), .dp_in(dp_in),
        .load(load), .blank_lz(blank_lz), .bright(bright), .an(an), .seg(seg),
        .dp(dp), .load_ack(load_ack), .frame(frame)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int nfail  = 0;
    int ce_cnt = 0;

    // reference model: time since reset, slots elapsed, time since slot start
    int          m_cyc, m_since, m_ticks, m_slot;
    logic [15:0] m_act, m_pen;
    logic [3:0]  m_adp, m_pdp;
    bit          m_pend, m_wrap, m_ack;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_frame, e_ack;

    logic [3:0] col_an[$];
    logic [6:0] col_seg[$];
    logic       col_dp[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0; m_since = 0; m_ticks = 0; m_slot = 0;
        m_act = '0; m_pen = '0; m_adp = '0; m_pdp = '0;
        m_pend = 0; m_wrap = 0; m_ack = 0;
    endtask

    task automatic step();
        int  d;
        bit  blank, wrap_n, ack_n;
        logic [3:0] nib;
        @(posedge clk);
        if (rst) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0; e_ack = 1'b0;
            model_reset();
        end else begin
            d       = m_slot % NDIG;
            nib     = 4'((m_act >> (4*d)) & 16'hF);
            blank   = blank_lz && d > 0 && ((m_act >> (4*d)) == 16'h0);
            e_seg   = blank ? 7'h7F : SEGTAB[nib];
            e_dp    = blank ? 1'b1 : ~m_adp[d];
            e_an    = (m_since >= G && ((m_cyc % 256) / 32) <= int'(bright)) ? ~(4'b0001 << d) : 4'hF;
            e_frame = m_wrap;
            e_ack   = m_ack;
            wrap_n = 0; ack_n = 0;
            m_cyc++; m_since++;
            if (ce1ms) begin
                m_ticks++;
                if (m_ticks == SLOT) begin
                    m_ticks = 0; m_slot++; m_since = 0;
                    if (m_slot % NDIG == 0) wrap_n = 1;
                end
            end
            if (wrap_n && m_pend) begin
                ack_n = 1; m_act = m_pen; m_adp = m_pdp; m_pend = 0;
            end
            if (load) begin
                m_pen = data_in; m_pdp = dp_in; m_pend = 1;
            end
            m_wrap = wrap_n; m_ack = ack_n;
        end
        #1;
        chk("an", an, e_an);
        chk("seg", seg, e_seg);
        chk("dp", dp, e_dp);
        chk("frame", frame, e_frame);
        chk("load_ack", load_ack, e_ack);
        load   = 1'b0;
        ce_cnt = (ce_cnt + 1) % CE_PER;
        ce1ms  = (ce_cnt == CE_PER - 1);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        data_in = v; dp_in = d; load = 1'b1;
        step();
    endtask

    task automatic wait_wrap(input string tag);
        bit got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            step();
            got = m_wrap;
        end
        chk(tag, got, 1);
    endtask

    // record (an, seg, dp) at each anode turn-on until the model's next wrap
    task automatic collect_frame();
        logic [3:0] prev = 4'hF;
        bit got = 0;
        col_an.delete(); col_seg.delete(); col_dp.delete();
        for (int i = 0; i < 3000 && !got; i++) begin
            step();
            if (an != 4'hF && prev == 4'hF) begin
                col_an.push_back(an); col_seg.push_back(seg); col_dp.push_back(dp);
            end
            prev = an;
            got  = m_wrap;
        end
        chk("collect_timeout", got, 1);
    endtask

    initial begin
        int n, n_ack, n_on, n_bad;
        bit found;
        logic [3:0]  exp_an  [4];
        logic [6:0]  exp_seg [4];
        model_reset();

        // reset held 3 clk, then time to first digit-0 anode
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        n = 0;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(); n++;
            found = (an == 4'hE);
        end
        chk("first_anode_delay", n, G + 1);

        // scan order with 12A8
        bright = 3'd7; blank_lz = 1'b0;
        do_load(16'h12A8, 4'h0);
        wait_wrap("wrap1");
        step();
        chk("frame_pulse", frame, 1);
        chk("ack_with_frame", load_ack, 1);
        collect_frame();
        exp_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
        exp_seg = '{7'h00, 7'h08, 7'h24, 7'h79};
        chk("scan_slots", col_an.size(), 4);
        for (int i = 0; i < 4 && i < col_an.size(); i++) begin
            chk("scan_an", col_an[i], exp_an[i]);
            chk("scan_seg", col_seg[i], exp_seg[i]);
        end
        step();

        // double buffer: last load before the wrap wins
        run(600);
        do_load(16'h1111, 4'h0);
        run(600);
        do_load(16'h2222, 4'h0);
        n_ack = 0;
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            step();
            n_ack += int'(load_ack);
            found = m_wrap;
        end
        chk("db_no_early_ack", n_ack, 0);
        step();
        chk("db_ack", load_ack, 1);
        chk("db_frame", frame, 1);
        collect_frame();
        n_bad = 0;
        for (int i = 0; i < col_seg.size(); i++) if (col_seg[i] != 7'h24) n_bad++;
        chk("db_shows_2222", n_bad, 0);
        chk("db_slots", col_seg.size(), 4);
        step();

        // leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h0030, 4'b1000);
        wait_wrap("wrap_lz");
        step();
        collect_frame();
        exp_seg = '{7'h40, 7'h30, 7'h7F, 7'h7F};
        chk("lz_slots", col_seg.size(), 4);
        for (int i = 0; i < 4 && i < col_seg.size(); i++) begin
            chk("lz_seg", col_seg[i], exp_seg[i]);
            chk("lz_dp", col_dp[i], 1);
        end
        step();

        // brightness 0: 32 of 256 clk within ON
        blank_lz = 1'b0; bright = 3'd0;
        run(40);
        n_on = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (an != 4'hF) n_on++;
        end
        chk("pwm_duty", n_on, 32);
        bright = 3'd7;

        // reset with pend set: pending discarded, no ack
        do_load(16'hAAAA, 4'hF);
        run(100);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        n_ack = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            n_ack += int'(load_ack);
        end
        chk("rst_pend_no_ack", n_ack, 0);

        // load in the wrap cycle is acked one frame later
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            found = ce1ms && m_ticks == SLOT - 1 && (m_slot % NDIG) == NDIG - 1;
            if (!found) step();
        end
        chk("found_boundary", found, 1);
        do_load(16'h7777, 4'h0);
        step();
        chk("bnd_frame", frame, 1);
        chk("bnd_no_ack", load_ack, 0);
        wait_wrap("wrap_bnd");
        step();
        chk("bnd_ack_next", load_ack, 1);

        // randomized phase
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                data_in = 16'($urandom); dp_in = 4'($urandom); load = 1'b1;
            end
            if ($urandom_range(0, 999) == 0) bright = 3'($urandom);
            if ($urandom_range(0, 1499) == 0) blank_lz = ~blank_lz;
            rst = ($urandom_range(0, 8999) == 0);
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a common-anode seven-segment display. Sequences NDIG digits using the 1 ms clock-enable strobe and hex-decodes a double-buffered value so that updates are applied only at frame boundaries. Also provides leading-zero blanking, brightness PWM and an inter-digit guard band against ghosting. Sits between the millisecond strobe generator and the display pins of the indicator lab module.

## Interface
Parameters:
- NDIG, 4: number of digits; data width is 4*NDIG.
- SLOT_TICKS, 2: ce1ms pulses per digit slot (≥1).
- GUARD_CLKS, 64: clk cycles with all anodes off at the start of each slot (≥1).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- ce1ms  in  1  one-clk strobe every 1 ms.
- data_in  in  4*NDIG  hex nibbles; nibble 0 is the rightmost digit.
- dp_in  in  NDIG  decimal points, 1 = lit.
- load  in  1  one-clk strobe; captures data_in/dp_in into the pending buffer.
- blank_lz  in  1  enables leading-zero blanking.
- bright  in  3  brightness level 0..7.
- an  out  NDIG  anodes, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- load_ack  out  1  one-clk pulse when pending data becomes active.
- frame  out  1  one-clk pulse when the scan wraps to digit 0.

## Operation
- Buffers:
  - load=1 writes data_in/dp_in to the pending buffer and sets pend.
  - A repeated load before the next boundary overwrites the pending buffer; the last value wins.
- Frame boundary (digit index wraps NDIG-1→0):
  - If pend was set before this cycle: active ← pending, pend ← 0, load_ack=1.
  - A load in the boundary cycle itself stays pending until the next boundary.
- Scan FSM, two states:
  - GUARD: all anodes off. Lasts GUARD_CLKS cycles, then → ON.
  - ON: anode of the current digit enabled, gated by PWM.
  - slot_cnt counts ce1ms pulses in both states. A ce1ms pulse with slot_cnt==SLOT_TICKS-1 resets slot_cnt to 0, advances the digit index (wrapping to 0), and enters GUARD.
- PWM: 8-bit free-running clk counter p. In ON, the anode is enabled iff p[7:5] ≤ bright. bright=7 gives always on; bright=0 gives 1/8 duty.
- Decode (active-low, gfedcba):
  - 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h
  - 8=00h, 9=10h, A=08h, b=03h, C=46h, d=21h, E=06h, F=0Eh
  - blank=7Fh
- Leading-zero blanking: digit k>0 is blanked (seg=7Fh, dp=1, anode still scanned) iff blank_lz=1 and nibbles NDIG-1..k of the active buffer are all zero. Digit 0 is never blanked. The dp of a blanked digit is suppressed.
- Outputs are registered, so pin changes lag the internal state by 1 clk.

## Timing
- Reset values:
  - an all 1, seg=7Fh, dp=1, load_ack=0, frame=0.
  - Digit index 0, state GUARD with guard count 0, slot_cnt=0, p=0.
  - Active and pending buffers 0, pend=0.
- After reset release, the digit 0 anode asserts GUARD_CLKS+1 clk later, subject to PWM.
- A ce1ms pulse during GUARD that ends the slot restarts GUARD for the next digit; the guard count is reset.
- frame and load_ack pulse in the cycle after the wrap, in the same cycle as the GUARD outputs for digit 0.
- rst mid-scan or with pend set:
  - All state returns to reset values the next cycle.
  - The pending data is discarded and no load_ack is issued.
- ce1ms and load in the same cycle are independent; both take effect.
- bright changes take effect within 1 clk.

## Test plan
- Reset check: hold rst 3 clk → an=1111, seg=7Fh, dp=1, load_ack=0, frame=0 throughout; after release, the first an=1110 appears GUARD_CLKS+1 clk later.
- Scan order, NDIG=4, SLOT_TICKS=2, bright=7:
  - Stimulus: load 16'h12A8; run the scan.
  - Expect an sequence 1110,1101,1011,0111 with seg 00h,08h,24h,79h.
  - Each slot lasts 2 ce1ms periods, with a GUARD gap of all-ones anodes between slots.
- Double buffer:
  - Stimulus: load 16'h1111 mid-frame, then load 16'h2222 before the wrap.
  - Expect the old value until the wrap, a single load_ack coincident with frame, then 2222 displayed; 1111 is never displayed.
- Leading-zero blanking: blank_lz=1, data 16'h0030, dp_in=4'b1000 → digits 3 and 2 seg=7Fh with dp=1; digit 1=30h; digit 0=40h.
- Brightness: bright=0 → within ON, the anode is low exactly 32 of every 256 clk (p[7:5]=0).
- Reset while pend is set, and load coinciding with the boundary:
  - Reset while pend=1 → no load_ack is issued and active=0.
  - Load in the boundary cycle → load_ack follows one frame later.
